pll_lock_supervisor: RTL



---
 rtl/pll_lock_if.sv | 28 ++
 rtl/pll_lock_supervisor.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/pll_lock_if.sv
`timescale 1ns/1ps
// Control/status bundle between the PLL lock supervisor and the PLL / system reset tree.
interface pll_lock_if #(
  parameter int unsigned MAX_RETRIES = 3
);
  localparam int unsigned RETRY_W = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  logic               pll_locked;
  logic               relock_req;
  logic               pll_rst;
  logic               sys_rst_n;
  logic               ready;
  logic               fault;
  logic [RETRY_W-1:0] retry_cnt;
  logic [7:0]         lock_loss_cnt;

  // Supervisor side
  modport master (
    input  pll_locked, relock_req,
    output pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt
  );

  // PLL / system side
  modport slave (
    output pll_locked, relock_req,
    input  pll_rst, sys_rst_n, ready, fault, retry_cnt, lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor.sv
`timescale 1ns/1ps
// PLL lock supervisor: pulses the PLL reset, debounces the synchronized lock
// flag, holds the system reset until lock is stable and retries on failure.
module pll_lock_supervisor #(
  parameter int unsigned PLL_RST_CYCLES      = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 65536,
  parameter int unsigned MAX_RETRIES         = 3,
  parameter int unsigned SYNC_STAGES         = 2
) (
  input  logic       refclk,
  input  logic       rst_n,
  pll_lock_if.master bus
);

  localparam int unsigned RETRY_W = ($clog2(MAX_RETRIES + 1) < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam int unsigned TMR_MAX_A = (PLL_RST_CYCLES > LOCK_STABLE_CYCLES) ? PLL_RST_CYCLES
                                                                             : LOCK_STABLE_CYCLES;
  localparam int unsigned TMR_MAX = (TMR_MAX_A > LOCK_TIMEOUT_CYCLES) ? TMR_MAX_A
                                                                      : LOCK_TIMEOUT_CYCLES;
  localparam int unsigned TMR_W = ($clog2(TMR_MAX) < 1) ? 1 : $clog2(TMR_MAX);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAULT     = 3'd4
  } state_e;

  state_e                 state_q, state_d;
  logic [TMR_W-1:0]       tmr_q, tmr_d;
  logic [RETRY_W-1:0]     retry_q, retry_d;
  logic [7:0]             loss_q, loss_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   pll_rst_q, pll_rst_d;
  logic                   sys_rst_n_q, sys_rst_n_d;
  logic                   ready_q, ready_d;
  logic                   fault_q, fault_d;
  logic                   locked_s;

  assign locked_s = sync_q[SYNC_STAGES-1];

  // Shift the asynchronous lock flag through the synchronizer chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], bus.pll_locked};
  end

  // State register, timers, counters, synchronizer and registered outputs
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      tmr_q       <= '0;
      retry_q     <= '0;
      loss_q      <= '0;
      sync_q      <= '0;
      pll_rst_q   <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
      fault_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      retry_q     <= retry_d;
      loss_q      <= loss_d;
      sync_q      <= sync_d;
      pll_rst_q   <= pll_rst_d;
      sys_rst_n_q <= sys_rst_n_d;
      ready_q     <= ready_d;
      fault_q     <= fault_d;
    end
  end

  // Next-state, counter updates; outputs are decoded from the next state so they register with it
  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    retry_d = retry_q;
    loss_d  = loss_q;

    unique case (state_q)
      S_RESET_PLL: begin
        if (bus.relock_req) begin
          tmr_d = '0;
        end else if (tmr_q == TMR_W'(PLL_RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_WAIT_LOCK: begin
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          tmr_d   = '0;
        end else if (locked_s) begin
          state_d = S_STABLE;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
          tmr_d = '0;
          if (retry_q == RETRY_W'(MAX_RETRIES)) begin
            state_d = S_FAULT;
          end else begin
            state_d = S_RESET_PLL;
            retry_d = retry_q + RETRY_W'(1);
          end
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_STABLE: begin
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          tmr_d   = '0;
        end else if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          tmr_d   = '0;
        end else if (tmr_q == TMR_W'(LOCK_STABLE_CYCLES - 1)) begin
          state_d = S_RUN;
          tmr_d   = '0;
          retry_d = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_RUN: begin
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          tmr_d   = '0;
        end else if (!locked_s) begin
          state_d = S_RESET_PLL;
          tmr_d   = '0;
          if (loss_q != 8'hFF) begin
            loss_d = loss_q + 8'd1;
          end
        end
      end

      S_FAULT: begin
        if (bus.relock_req) begin
          state_d = S_RESET_PLL;
          tmr_d   = '0;
          retry_d = '0;
        end
      end

      default: begin
        state_d = S_RESET_PLL;
        tmr_d   = '0;
      end
    endcase

    pll_rst_d   = (state_d == S_RESET_PLL) || (state_d == S_FAULT);
    sys_rst_n_d = (state_d == S_RUN);
    ready_d     = (state_d == S_RUN);
    fault_d     = (state_d == S_FAULT);
  end

  assign bus.pll_rst       = pll_rst_q;
  assign bus.sys_rst_n     = sys_rst_n_q;
  assign bus.ready         = ready_q;
  assign bus.fault         = fault_q;
  assign bus.retry_cnt     = retry_q;
  assign bus.lock_loss_cnt = loss_q;

endmodule
